fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and the decode stage.
- Captures {inst_F, pc_plus4_F} each cycle that fetch produces a valid instruction.
- Presents the oldest entry to decode as {inst_D, pc_plus4_D, valid_D}.
- Decouples decode stalls from fetch, and discards wrong-path instructions on a decode-stage redirect (flush).

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- N, 32, width of the instruction and pc_plus4 fields.

Ports:
- ctrl_bus.clk  input  1  clock, rising edge; delivered through the ctrl_bus_if.central modport.
- ctrl_bus.reset  input  1  asynchronous, active-high reset; delivered through ctrl_bus.
- inst_F  input  N  instruction word from fetch.
- pc_plus4_F  input  N  PC+4 of inst_F.
- push_F  input  1  fetch presents a valid instruction this cycle.
- full_F  output  1  queue cannot accept a push unless a pop occurs in the same cycle; fetch uses !full_F as pc_enab.
- stall_D  input  1  decode cannot consume this cycle.
- flush_D  input  1  redirect in decode (pc_src_D); discard all queued and incoming instructions.
- inst_D  output  N  head instruction; 32'h0 (NOP) when empty.
- pc_plus4_D  output  N  head PC+4; 0 when empty.
- valid_D  output  1  head entry valid.
- count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry circular buffer of {inst, pc_plus4}, with rd_ptr and wr_ptr of $clog2(DEPTH) bits.
  - Pointers wrap naturally modulo DEPTH.
  - Occupancy is held in a separate count register; no ptr-extension trick.
- Reset (async, reset=1): rd_ptr=0, wr_ptr=0, count=0 immediately, without waiting for a clock edge.
  - Resulting outputs: valid_D=0, full_F=0, inst_D=0, pc_plus4_D=0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all entries.
  - The first push after reset deassertion is accepted normally.
- Outputs are combinational from state only:
  - valid_D = (count!=0).
  - full_F = (count==DEPTH).
  - inst_D/pc_plus4_D = mem[rd_ptr] when valid_D, else 0.
  - No input-to-output combinational path.
- pop = valid_D & !stall_D & !flush_D.
- push_ok = push_F & !flush_D & (!full_F | pop).
- Each rising edge, priority order:
  1. flush_D=1: rd_ptr<=wr_ptr and count<=0. Any push in the same cycle is dropped. flush overrides stall.
  2. Otherwise, on push_ok: mem[wr_ptr]<={inst_F,pc_plus4_F} and wr_ptr++.
  3. Otherwise, on pop: rd_ptr++.
  4. count <= count + push_ok − pop.
- Simultaneous push and pop:
  - When full: both are accepted, count stays at DEPTH, FIFO order is preserved.
  - When empty: pop=0 because valid_D=0, so the push lands and count becomes 1.
- Latency: an instruction pushed at edge k is visible on inst_D after edge k, i.e. one cycle, equivalent to an IF/ID register. There is no empty-bypass path.
- push_F=1 while full_F=1 and no pop: the push is ignored. Fetch is required to hold its PC (pc_enab=0), so the instruction is re-presented.
- stall_D=1 with valid_D=1: head entry and outputs are held stable.
- Ordering is strict FIFO across pointer wrap-around.
- Target size: ~150–250 lines of RTL, including an optional assertion block.
- Assertions:
  - count never exceeds DEPTH.
  - count never underflows.
  - valid_D==0 implies inst_D==0.

Test Plan:
- Reset mid-stream: push 3 entries, then assert reset between edges → count=0, valid_D=0, inst_D=0 immediately. After release, push 32'hAAAA_0001 → next cycle inst_D=32'hAAAA_0001.
- Stall fill: stall_D=1, push I0..I3 (inst=0x100+i, pc_plus4=0x4*(i+1)) → count=4, full_F=1. A fifth push is ignored, count stays 4. Release stall → inst_D shows I0,I1,I2,I3 on consecutive cycles, then valid_D=0.
- Full push+pop: queue full with stall_D=0 and push_F=1 (I4) → count stays 4, output order I0,I1,I2,I3,I4.
- Flush: queue holds 2 entries, flush_D=1 with push_F=1 and stall_D=1 in the same cycle → next cycle count=0, valid_D=0, inst_D=0. The following push appears one cycle later.
- Streaming wrap: 10 consecutive cycles of push_F=1, stall_D=0 with inst=i → inst_D=i exactly one cycle after each push, count stays 1, both pointers wrap twice with no reorder or loss.
- Empty pop: stall_D=0, push_F=0, count=0 → count remains 0 and no pointer movement occurs (rd_ptr unchanged).

Source files
------------

// File: rtl/ctrl_bus_if.sv
// Clock/reset bundle shared by pipeline blocks.
// The source side drives the bundle; central is the consuming view.
interface ctrl_bus_if;
    logic clk;
    logic reset;

    modport master  (output clk, output reset);
    modport central (input clk, input reset);
endinterface

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer.
// A circular buffer of {inst, pc_plus4} pairs sits between fetch and decode.
// Decode sees the oldest entry one cycle after it was pushed; there is no empty bypass.
// A decode redirect (flush_D) drops every queued entry and any same-cycle push.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned N     = 32
) (
    ctrl_bus_if.central            ctrl_bus,
    input  logic [N-1:0]           inst_F,
    input  logic [N-1:0]           pc_plus4_F,
    input  logic                   push_F,
    output logic                   full_F,
    input  logic                   stall_D,
    input  logic                   flush_D,
    output logic [N-1:0]           inst_D,
    output logic [N-1:0]           pc_plus4_D,
    output logic                   valid_D,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    // Entry layout: inst in the upper half, pc_plus4 in the lower half.
    logic [2*N-1:0] mem [DEPTH];

    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    cnt_t count_q, count_d;

    logic pop;
    logic push_ok;

    // Outputs depend on registered state only.
    assign valid_D    = (count_q != '0);
    assign full_F     = (count_q == cnt_t'(DEPTH));
    assign inst_D     = valid_D ? mem[rd_ptr_q][2*N-1:N] : '0;
    assign pc_plus4_D = valid_D ? mem[rd_ptr_q][N-1:0]   : '0;
    assign count      = count_q;

    // A full queue still takes a push when the head leaves in the same cycle.
    assign pop     = valid_D & ~stall_D & ~flush_D;
    assign push_ok = push_F & ~flush_D & (~full_F | pop);

    // Next-state for pointers and occupancy; flush wins over push, pop and stall.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_D) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push_ok) - cnt_t'(pop);
        end
    end

    // Pointer and occupancy state, cleared asynchronously by reset.
    always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.reset) begin
        if (ctrl_bus.reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge ctrl_bus.clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {inst_F, pc_plus4_F};
        end
    end

    // Occupancy stays within 0..DEPTH and an empty head reads as a NOP.
    a_count_max: assert property (@(posedge ctrl_bus.clk) disable iff (ctrl_bus.reset)
        count_q <= cnt_t'(DEPTH));
    a_no_underflow: assert property (@(posedge ctrl_bus.clk) disable iff (ctrl_bus.reset)
        !(count_q == '0 && pop));
    a_empty_nop: assert property (@(posedge ctrl_bus.clk) disable iff (ctrl_bus.reset)
        !valid_D |-> (inst_D == '0 && pc_plus4_D == '0));

endmodule
